// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT)
module core_ctrl #(
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    input  logic                imem_ready,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    input  logic [6:0]          ir_opcode,
    input  logic [2:0]          ir_funct3,
    input  logic                ir_funct7_5,
    input  logic                alu_zero,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_we,
    output logic [1:0]          wb_sel,
    output logic                halted,
    output logic                illegal,
    output logic [2:0]          state
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;
    state_e state_q, state_d;
    logic illegal_q, illegal_d;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opimm, is_op, is_sys;
    logic known, bad, f7_eff;
    logic [ALU_OP_W-1:0] alu_fn;
    assign is_lui   = ir_opcode == OPC_LUI;
    assign is_auipc = ir_opcode == OPC_AUIPC;
    assign is_jal   = ir_opcode == OPC_JAL;
    assign is_jalr  = ir_opcode == OPC_JALR;
    assign is_br    = ir_opcode == OPC_BRANCH;
    assign is_ld    = ir_opcode == OPC_LOAD;
    assign is_st    = ir_opcode == OPC_STORE;
    assign is_opimm = ir_opcode == OPC_OPIMM;
    assign is_op    = ir_opcode == OPC_OP;
    assign is_sys   = ir_opcode == OPC_SYSTEM;
    assign known = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_opimm | is_op | is_sys;
    assign bad = !known
               | (is_br & (ir_funct3[2:1] != 2'b00))
               | ((is_ld | is_st) & (ir_funct3 != 3'b010))
               | (is_jalr & (ir_funct3 != 3'b000));
    // funct7[5] selects SUB only for register OP; SRA/SRL for both forms
    assign f7_eff = ir_funct7_5 & ((ir_funct3 == 3'b101) | (is_op & (ir_funct3 == 3'b000)));
    always_comb begin
        case (ir_funct3)
            3'b000:  alu_fn = f7_eff ? ALU_OP_W'(1) : ALU_OP_W'(0);
            3'b001:  alu_fn = ALU_OP_W'(2);
            3'b010:  alu_fn = ALU_OP_W'(3);
            3'b011:  alu_fn = ALU_OP_W'(4);
            3'b100:  alu_fn = ALU_OP_W'(5);
            3'b101:  alu_fn = f7_eff ? ALU_OP_W'(7) : ALU_OP_W'(6);
            3'b110:  alu_fn = ALU_OP_W'(8);
            default: alu_fn = ALU_OP_W'(9);
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  state_d = imem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d   = (bad | is_sys) ? S_HALT : S_EXEC;
                illegal_d = bad;
            end
            S_EXEC:   state_d = (is_ld | is_st) ? S_MEM
                              : (is_op | is_opimm | is_lui | is_auipc) ? S_WB : S_FETCH;
            S_MEM:    state_d = !dmem_ready ? S_MEM : is_ld ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = ALU_OP_W'(0);
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    alu_src_a = is_lui ? 2'd2 : is_auipc ? 2'd1 : 2'd0;
                    alu_src_b = (is_op | is_br | is_jal) ? 2'd0 : 2'd1;
                    alu_op    = is_br ? ALU_OP_W'(1) : (is_op | is_opimm) ? alu_fn : ALU_OP_W'(0);
                    pc_we     = is_br | is_jal | is_jalr;
                    pc_sel    = is_jalr ? 2'd2 : is_jal ? 2'd1
                              : (is_br & (alu_zero ^ ir_funct3[0])) ? 2'd1 : 2'd0;
                    reg_we    = is_jal | is_jalr;
                    wb_sel    = (is_jal | is_jalr) ? 2'd2 : 2'd0;
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    dmem_we   = is_st;
                    alu_src_b = 2'd1;
                    pc_we     = is_st & dmem_ready;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    wb_sel = is_ld ? 2'd1 : 2'd0;
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end
    assign halted  = state_q == S_HALT;
    assign illegal = illegal_q;
    assign state   = state_q;
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: per-cycle trace check of core_ctrl against an instruction-level reference model
module tb_core_ctrl;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] OPS [9] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
    typedef struct packed {
        logic [2:0] st;
        logic       ireq, irwe, dreq, dwe, pcwe;
        logic [1:0] pcs, sa, sb;
        logic [3:0] op;
        logic       rwe;
        logic [1:0] wb;
        logic       hl, il;
    } ov_t;
    typedef struct {
        ov_t   v;
        logic  ir, dr, z, instr;
        string ph;
    } cyc_t;
    logic clk = 1'b0;
    logic reset, imem_ready, dmem_ready, alu_zero, ir_funct7_5;
    logic [6:0] ir_opcode;
    logic [2:0] ir_funct3;
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, halted, illegal;
    logic [1:0] pc_sel, alu_src_a, alu_src_b, wb_sel;
    logic [3:0] alu_op;
    logic [2:0] state;
    int total = 0, passed = 0, n_ins = 0;
    cyc_t q[$];
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    always #5 clk = ~clk;
    core_ctrl #(.ALU_OP_W(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ir_opcode(ir_opcode), .ir_funct3(ir_funct3), .ir_funct7_5(ir_funct7_5),
        .alu_zero(alu_zero), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted), .illegal(illegal), .state(state)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic ov_t dut_v();
        ov_t o;
        o = '{st: state, ireq: imem_req, irwe: ir_we, dreq: dmem_req, dwe: dmem_we, pcwe: pc_we,
              pcs: pc_sel, sa: alu_src_a, sb: alu_src_b, op: alu_op, rwe: reg_we, wb: wb_sel,
              hl: halted, il: illegal};
        return o;
    endfunction
    // ALU opcode table from the instruction set: f7 picks SUB (register form) and SRA
    function automatic logic [3:0] alu_ref(input logic f7, input logic [2:0] f3, input logic imm);
        case (f3)
            3'd0:    return (f7 && !imm) ? 4'd1 : 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd4;
            3'd4:    return 4'd5;
            3'd5:    return f7 ? 4'd7 : 4'd6;
            3'd6:    return 4'd8;
            default: return 4'd9;
        endcase
    endfunction
    task automatic add(input ov_t v, input logic ir, input logic dr, input logic z, input logic instr, input string ph);
        cyc_t c;
        c.v = v; c.ir = ir; c.dr = dr; c.z = z; c.instr = instr; c.ph = ph;
        q.push_back(c);
    endtask
    task automatic build(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input int zmode, input int iw, input int dw, input int nhalt);
        ov_t e;
        logic ld, st, known, legal, z, wb_needed;
        ld = opc == LOAD;
        st = opc == STORE;
        known = opc inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM};
        legal = known && !(opc == BRANCH && f3 > 3'd1) && !((ld || st) && f3 != 3'd2)
                && !(opc == JALR && f3 != 3'd0);
        wb_needed = opc inside {OP, OPIMM, LUI, AUIPC, LOAD};
        q.delete();
        cur_op = opc; cur_f3 = f3; cur_f7 = f7;
        for (int i = 0; i <= iw; i++) begin
            e = '0; e.ireq = 1'b1; e.irwe = 1'(i == iw);
            add(e, 1'(i == iw), 1'($urandom), 1'($urandom), 1'b0, "fetch");
        end
        e = '0; e.st = 3'd1;
        add(e, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, "decode");
        if (!legal || opc == SYSTEM) begin
            for (int i = 0; i < nhalt; i++) begin
                e = '0; e.st = 3'd5; e.hl = 1'b1; e.il = !legal;
                add(e, 1'b1, 1'($urandom), 1'($urandom), 1'b1, "halt");
            end
            return;
        end
        z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
        e = '0; e.st = 3'd2;
        case (opc)
            OP:     e.op = alu_ref(f7, f3, 1'b0);
            OPIMM:  begin e.sb = 2'd1; e.op = alu_ref(f7, f3, 1'b1); end
            LUI:    begin e.sa = 2'd2; e.sb = 2'd1; end
            AUIPC:  begin e.sa = 2'd1; e.sb = 2'd1; end
            LOAD, STORE: e.sb = 2'd1;
            BRANCH: begin e.op = 4'd1; e.pcwe = 1'b1; e.pcs = ((f3 == 3'd0) ? z : !z) ? 2'd1 : 2'd0; end
            JAL:    begin e.rwe = 1'b1; e.wb = 2'd2; e.pcwe = 1'b1; e.pcs = 2'd1; end
            default: begin e.sb = 2'd1; e.rwe = 1'b1; e.wb = 2'd2; e.pcwe = 1'b1; e.pcs = 2'd2; end
        endcase
        add(e, 1'($urandom), 1'($urandom), z, 1'b1, "exec");
        if (ld || st) begin
            for (int i = 0; i <= dw; i++) begin
                e = '0; e.st = 3'd3; e.dreq = 1'b1; e.dwe = st; e.sb = 2'd1; e.pcwe = st && i == dw;
                add(e, 1'($urandom), 1'(i == dw), 1'($urandom), 1'b1, "mem");
            end
        end
        if (wb_needed) begin
            e = '0; e.st = 3'd4; e.rwe = 1'b1; e.wb = ld ? 2'd1 : 2'd0; e.pcwe = 1'b1;
            add(e, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, "wb");
        end
    endtask
    task automatic run(input int limit);
        n_ins++;
        for (int i = 0; i < q.size() && i != limit; i++) begin
            imem_ready = q[i].ir;
            dmem_ready = q[i].dr;
            alu_zero   = q[i].z;
            if (q[i].instr) begin
                ir_opcode = cur_op; ir_funct3 = cur_f3; ir_funct7_5 = cur_f7;
            end else begin
                ir_opcode = 7'($urandom); ir_funct3 = 3'($urandom); ir_funct7_5 = 1'($urandom);
            end
            #1;
            chk($sformatf("i%0d_%s%0d", n_ins, q[i].ph, i), 32'(dut_v()), 32'(q[i].v));
            @(posedge clk);
            #1;
        end
    endtask
    task automatic rst_cycle(input string tag);
        reset = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        #1;
        chk({tag, "_strobes"}, 32'({imem_req, dmem_req, ir_we, pc_we, reg_we, dmem_we}), 32'd0);
        chk({tag, "_selects"}, 32'({pc_sel, alu_src_a, alu_src_b, alu_op, wb_sel}), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_state"}, 32'({state, halted, illegal}), 32'd0);
        reset = 1'b1;
    endtask
    initial begin
        logic [6:0] o;
        logic [2:0] f;
        reset = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0; alu_zero = 1'b0;
        ir_opcode = '0; ir_funct3 = '0; ir_funct7_5 = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) rst_cycle($sformatf("rst%0d", k));
        build(OP, 3'd0, 1'b1, 2, 0, 0, 0);     run(-1);
        build(LOAD, 3'd2, 1'b0, 2, 0, 2, 0);   run(-1);
        build(STORE, 3'd2, 1'b1, 2, 1, 0, 0);  run(-1);
        build(BRANCH, 3'd0, 1'b0, 1, 0, 0, 0); run(-1);
        build(BRANCH, 3'd1, 1'b0, 1, 0, 0, 0); run(-1);
        build(BRANCH, 3'd1, 1'b0, 0, 2, 0, 0); run(-1);
        build(JAL, 3'd5, 1'b1, 2, 0, 0, 0);    run(-1);
        build(JALR, 3'd0, 1'b0, 2, 0, 0, 0);   run(-1);
        build(OPIMM, 3'd0, 1'b1, 2, 0, 0, 0);  run(-1);
        build(OPIMM, 3'd5, 1'b1, 2, 0, 0, 0);  run(-1);
        build(OP, 3'd5, 1'b1, 2, 0, 0, 0);     run(-1);
        build(LUI, 3'd3, 1'b0, 2, 0, 0, 0);    run(-1);
        build(AUIPC, 3'd7, 1'b1, 2, 0, 0, 0);  run(-1);
        for (int n = 0; n < 80; n++) begin
            o = OPS[$urandom_range(0, 8)];
            f = 3'($urandom);
            if (o == BRANCH) f = {2'b00, 1'($urandom)};
            if (o == LOAD || o == STORE) f = 3'd2;
            if (o == JALR) f = 3'd0;
            build(o, f, 1'($urandom), 2, $urandom_range(0, 2), $urandom_range(0, 2), 0);
            run(-1);
        end
        build(BRANCH, 3'd4, 1'b0, 2, 0, 0, 10); run(-1); rst_cycle("rst_bad_branch");
        build(SYSTEM, 3'd0, 1'b0, 2, 1, 0, 4);  run(-1); rst_cycle("rst_system");
        build(7'b1111111, 3'd0, 1'b0, 2, 0, 0, 3); run(-1); rst_cycle("rst_unknown");
        build(LOAD, 3'd0, 1'b0, 2, 0, 0, 3);    run(-1); rst_cycle("rst_bad_load");
        build(JALR, 3'd1, 1'b0, 2, 0, 0, 3);    run(-1); rst_cycle("rst_bad_jalr");
        build(LOAD, 3'd2, 1'b0, 2, 0, 5, 0);    run(5);  rst_cycle("rst_mid_mem");
        build(OP, 3'd7, 1'b0, 2, 0, 0, 0);      run(-1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
